b11_param_scrambler: RTL and testbench

//  Parametrised successor of the b11 string-scrambler FSM: accepts one W-bit symbol per transaction,

---
 rtl/b11_param_scrambler.sv | 146 ++++++++++++++
 tb/tb_b11_param_scrambler.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/b11_param_scrambler.sv
// Parametrised b11-style symbol scrambler: classifies each symbol, folds it with a running
// special-symbol count through a signed accumulator, offsets it and returns the magnitude.
module b11_param_scrambler #(
    parameter int W        = 6,
    parameter int LIM      = 26,
    parameter int CMAX     = 25,
    parameter int MAX_ITER = 15,
    parameter int ADJ0     = -21,
    parameter int ADJ1     = -42,
    parameter int ADJ2     = 7,
    parameter int ADJ3     = 28
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         out_err,
    input  logic         out_ready,
    output logic         drop,
    output logic [W-1:0] count_o
);

    localparam int AW = W + 3;
    localparam int IW = $clog2(MAX_ITER + 1);
    localparam logic signed [AW-1:0] LIM_P    = AW'(LIM);
    localparam logic signed [AW-1:0] LIM_N    = -LIM_P;
    localparam logic [IW-1:0]        ITER_MAX = IW'(MAX_ITER);

    typedef enum logic [2:0] {
        IDLE, CLASSIFY, SEED, COMBINE, RPOS, RNEG, ADJUST, EMIT
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [W-1:0]          r;
    logic [W-1:0]          count;
    logic signed [AW-1:0]  acc;
    logic signed [AW-1:0]  adj;
    logic signed [AW-1:0]  acc_adj;
    logic [W-1:0]          mag;
    logic [IW-1:0]         iter;
    logic                  special;
    logic                  pos_go;
    logic                  neg_go;

    assign count_o = count;
    assign special = (r == '0) || (&r);
    assign pos_go  = (acc > LIM_P) && (iter < ITER_MAX);
    assign neg_go  = (acc < LIM_N) && (iter < ITER_MAX);

    // Offset selection and magnitude of the adjusted accumulator; the most-negative
    // value keeps the low bits of its wrapped negate.
    always_comb begin
        adj = AW'(ADJ0);
        case (r[3:2])
            2'b00:   adj = AW'(ADJ0);
            2'b01:   adj = AW'(ADJ1);
            2'b10:   adj = AW'(ADJ2);
            default: adj = AW'(ADJ3);
        endcase
        acc_adj = acc + adj;
        mag     = acc_adj[AW-1] ? W'(-acc_adj) : acc_adj[W-1:0];
    end

    always_ff @(posedge clock) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = (state == IDLE);
        out_valid  = (state == EMIT);
        drop       = 1'b0;
        case (state)
            IDLE:     if (in_valid) state_next = CLASSIFY;
            CLASSIFY: begin
                if (special)               state_next = EMIT;
                else if (r <= W'(LIM))     state_next = SEED;
                else begin
                    drop       = 1'b1;
                    state_next = IDLE;
                end
            end
            SEED:     state_next = COMBINE;
            COMBINE:  state_next = r[1] ? RPOS : RNEG;
            RPOS:     if (!pos_go) state_next = ADJUST;
            RNEG:     if (!neg_go) state_next = ADJUST;
            ADJUST:   state_next = EMIT;
            EMIT:     if (out_ready) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Datapath registers; out_data/out_err are only written on the way into EMIT,
    // so they hold steady under backpressure.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r        <= '0;
            acc      <= '0;
            iter     <= '0;
            count    <= '0;
            out_data <= '0;
            out_err  <= 1'b0;
        end else begin
            case (state)
                IDLE:     if (in_valid) r <= in_data;
                CLASSIFY: if (special) begin
                    count    <= (count < W'(CMAX)) ? count + 1'b1 : '0;
                    out_data <= r;
                    out_err  <= 1'b0;
                end
                SEED:     acc <= r[0] ? AW'({count, 1'b0}) : AW'(count);
                COMBINE: begin
                    iter <= '0;
                    acc  <= r[1] ? AW'(r) + acc : AW'(r) - acc;
                end
                RPOS: begin
                    if (pos_go) begin
                        acc  <= acc - LIM_P;
                        iter <= iter + 1'b1;
                    end else begin
                        out_err <= (iter == ITER_MAX) && (acc > LIM_P);
                    end
                end
                RNEG: begin
                    if (neg_go) begin
                        acc  <= acc + LIM_P;
                        iter <= iter + 1'b1;
                    end else begin
                        out_err <= (iter == ITER_MAX) && (acc < LIM_N);
                    end
                end
                ADJUST: begin
                    acc      <= acc_adj;
                    out_data <= mag;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_b11_param_scrambler.sv
// Directed bench for b11_param_scrambler: a default instance plus a MAX_ITER=1 instance
// sharing the same stimulus.
`timescale 1ns/1ps
module tb_b11_param_scrambler;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic [5:0] in_data = '0;
    logic       out_ready = 1'b0;

    logic       in_ready, out_valid, out_err, drop;
    logic [5:0] out_data, count_o;
    logic       in_ready1, out_valid1, out_err1, drop1;
    logic [5:0] out_data1, count_o1;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clock = ~clock;

    b11_param_scrambler u_dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_err(out_err), .out_ready(out_ready), .drop(drop), .count_o(count_o)
    );

    b11_param_scrambler #(.MAX_ITER(1)) u_dut1 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready1), .out_valid(out_valid1), .out_data(out_data1),
        .out_err(out_err1), .out_ready(out_ready), .drop(drop1), .count_o(count_o1)
    );

    task automatic do_reset;
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    // Returns one cycle after the accepting edge
    task automatic send(input logic [5:0] sym);
        in_data  = sym;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    // Latency counts the accepting edge as 1
    task automatic wait_valid(output int lat);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clock);
            #1;
            lat++;
        end
        tests_run++;
        if (out_valid !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL out_valid_timeout got=%b expected=1", out_valid);
        end
    endtask

    task automatic handshake;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        tests_run++;
        if ({in_ready, out_valid, out_err, drop} !== 4'b1000) begin
            tests_failed++;
            $display("[TB] FAIL reset_flags got=%b expected=1000", {in_ready, out_valid, out_err, drop});
        end
        tests_run++;
        if (out_data !== 6'd0 || count_o !== 6'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_data got=%0d/%0d expected=0/0", out_data, count_o);
        end
    endtask

    task automatic test_special;
        int lat;
        do_reset();
        send(6'd0);
        wait_valid(lat);
        tests_run++;
        if (lat != 2 || out_data !== 6'd0 || count_o !== 6'd1) begin
            tests_failed++;
            $display("[TB] FAIL special_zero got lat=%0d data=%0d cnt=%0d expected 2/0/1", lat, out_data, count_o);
        end
        handshake();
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL special_release got valid=%b ready=%b expected 0/1", out_valid, in_ready);
        end
        send(6'd63);
        wait_valid(lat);
        tests_run++;
        if (lat != 2 || out_data !== 6'd63 || count_o !== 6'd2) begin
            tests_failed++;
            $display("[TB] FAIL special_ones got lat=%0d data=%0d cnt=%0d expected 2/63/2", lat, out_data, count_o);
        end
        handshake();
    endtask

    task automatic test_normal;
        int lat;
        do_reset();
        send(6'd5);
        wait_valid(lat);
        tests_run++;
        if (lat != 6 || out_data !== 6'd37 || out_err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL normal_5 got lat=%0d data=%0d err=%b expected 6/37/0", lat, out_data, out_err);
        end
        handshake();
    endtask

    task automatic test_boundary_drop;
        int lat;
        int seen;
        do_reset();
        send(6'd26);
        wait_valid(lat);
        tests_run++;
        if (lat != 6 || out_data !== 6'd33 || out_err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL limit_26 got lat=%0d data=%0d err=%b expected 6/33/0", lat, out_data, out_err);
        end
        handshake();
        send(6'd40);
        tests_run++;
        if (drop !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL drop_pulse got=%b expected=1", drop);
        end
        seen = 0;
        repeat (8) begin
            @(posedge clock);
            #1;
            if (out_valid === 1'b1 || drop === 1'b1) seen++;
        end
        tests_run++;
        if (seen != 0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL drop_quiet got extra=%0d ready=%b expected 0/1", seen, in_ready);
        end
    endtask

    task automatic test_wrap_and_loop;
        int lat;
        int lat0;
        int lat1;
        int c;
        do_reset();
        repeat (25) begin
            send(6'd0);
            wait_valid(lat);
            handshake();
        end
        tests_run++;
        if (count_o !== 6'd25 || count_o1 !== 6'd25) begin
            tests_failed++;
            $display("[TB] FAIL count_25 got=%0d/%0d expected=25/25", count_o, count_o1);
        end
        send(6'd3);
        lat0 = 0;
        lat1 = 0;
        c = 1;
        while (c < 40) begin
            if (lat0 == 0 && out_valid === 1'b1) lat0 = c;
            if (lat1 == 0 && out_valid1 === 1'b1) lat1 = c;
            if (lat0 != 0 && lat1 != 0) break;
            @(posedge clock);
            #1;
            c++;
        end
        tests_run++;
        if (lat0 != 8 || out_data !== 6'd20 || out_err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL loop_k2 got lat=%0d data=%0d err=%b expected 8/20/0", lat0, out_data, out_err);
        end
        tests_run++;
        if (lat1 != 7 || out_data1 !== 6'd6 || out_err1 !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL loop_trunc got lat=%0d data=%0d err=%b expected 7/6/1", lat1, out_data1, out_err1);
        end
        handshake();
        send(6'd0);
        wait_valid(lat);
        tests_run++;
        if (count_o !== 6'd0 || count_o1 !== 6'd0 || out_data !== 6'd0) begin
            tests_failed++;
            $display("[TB] FAIL count_wrap got=%0d/%0d data=%0d expected=0/0/0", count_o, count_o1, out_data);
        end
        handshake();
    endtask

    task automatic test_backpressure;
        int lat;
        int bad;
        do_reset();
        send(6'd5);
        wait_valid(lat);
        bad = 0;
        in_data  = 6'd63;
        in_valid = 1'b1;
        repeat (10) begin
            @(posedge clock);
            #1;
            if (out_valid !== 1'b1 || out_data !== 6'd37 || out_err !== 1'b0 || in_ready !== 1'b0) bad++;
        end
        in_valid = 1'b0;
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("[TB] FAIL hold_stable got bad_cycles=%0d expected=0", bad);
        end
        handshake();
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || count_o !== 6'd0) begin
            tests_failed++;
            $display("[TB] FAIL hold_release got valid=%b ready=%b cnt=%0d expected 0/1/0", out_valid, in_ready, count_o);
        end
    endtask

    task automatic test_reset_midloop;
        int lat;
        do_reset();
        send(6'd63);
        wait_valid(lat);
        handshake();
        send(6'd26);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        tests_run++;
        if ({in_ready, out_valid, out_err, drop} !== 4'b1000 || out_data !== 6'd0 || count_o !== 6'd0) begin
            tests_failed++;
            $display("[TB] FAIL midloop_reset got flags=%b data=%0d cnt=%0d expected 1000/0/0",
                     {in_ready, out_valid, out_err, drop}, out_data, count_o);
        end
        send(6'd5);
        wait_valid(lat);
        tests_run++;
        if (lat != 6 || out_data !== 6'd37) begin
            tests_failed++;
            $display("[TB] FAIL midloop_recover got lat=%0d data=%0d expected 6/37", lat, out_data);
        end
        handshake();
    endtask

    initial begin
        test_reset();
        test_special();
        test_normal();
        test_boundary_drop();
        test_wrap_and_loop();
        test_backpressure();
        test_reset_midloop();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
